fifo_sync_prog: RTL and testbench

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 117 +++++++++++
 tb/tb_fifo_sync_prog.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - synchronous FIFO with run-time almost-full/almost-empty thresholds and sticky errors
// Optional first-word-fall-through output stage enabled by FIFO_SYNC_PROG_FWFT_EN.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic [ADDR_WIDTH:0]   i_afull_thresh,
  input  logic [ADDR_WIDTH:0]   i_aempty_thresh,
  input  logic                  i_clr_err,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_en;
  logic                  wr_en;

  assign o_count       = count;
  assign o_full        = (count == DEPTH_C);
`ifdef FIFO_SYNC_PROG_FWFT_EN
  assign o_empty       = !o_valid;
`else
  assign o_empty       = (count == '0);
`endif
  assign o_almostfull  = (count >= i_afull_thresh);
  assign o_almostempty = (count <= i_aempty_thresh);

  // A read frees a slot this cycle, so a full FIFO can still take a write alongside it.
  assign rd_en = i_rd && !o_empty;
  assign wr_en = i_wr && (!o_full || rd_en);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
  end

`ifdef FIFO_SYNC_PROG_FWFT_EN
  // count includes the word parked in the output register; mem_cnt is what is left in the array.
  logic [ADDR_WIDTH:0] mem_cnt;
  logic                load;
  assign mem_cnt = count - {{ADDR_WIDTH{1'b0}}, o_valid};
  assign load    = (!o_valid || rd_en) && (mem_cnt != '0);
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end

`ifdef FIFO_SYNC_PROG_FWFT_EN
      if (load) begin
        o_data  <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        o_valid <= 1'b1;
      end else if (rd_en) begin
        o_valid <= 1'b0;
      end
`else
      if (rd_en) begin
        o_data  <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
`endif

      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase

      // Sticky errors: a new error in the clearing cycle keeps the flag set.
      if (i_wr && !wr_en) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end

      if (i_rd && !rd_en) begin
        o_underflow <= 1'b1;
      end else if (i_clr_err) begin
        o_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - directed self-checking bench for fifo_sync_prog (ADDR_WIDTH=2)
module tb_fifo_sync_prog;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] dout;
  logic          valid;
  logic [AW:0]   afull_th = 3'd3;
  logic [AW:0]   aempty_th = 3'd1;
  logic          clr = 1'b0;
  logic [AW:0]   count;
  logic          full, empty, afull, aempty, ovf, udf;

  int passed = 0;
  int total = 0;

  fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_data(din), .i_rd(rd),
    .o_data(dout), .o_valid(valid),
    .i_afull_thresh(afull_th), .i_aempty_thresh(aempty_th), .i_clr_err(clr),
    .o_count(count), .o_full(full), .o_empty(empty),
    .o_almostfull(afull), .o_almostempty(aempty),
    .o_overflow(ovf), .o_underflow(udf)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    #3;
    total++;
    if ({count, empty, full, valid, ovf, udf} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_flags: count=%0d empty=%b full=%b valid=%b ovf=%b udf=%b, need 0 1 0 0 0 0",
               count, empty, full, valid, ovf, udf);
    else passed++;
    total++;
    if (dout !== 8'h00) $display("FAIL reset_data: got %h need 00", dout); else passed++;
    cycle();
    rstn = 1'b1;
  endtask

`ifndef FIFO_SYNC_PROG_FWFT_EN
  task automatic test_order();
    logic [DW-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = vals[i];
      cycle();
      total++;
      if (count !== 3'(i + 1)) $display("FAIL order_wcount%0d: got %0d need %0d", i, count, i + 1); else passed++;
    end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (valid !== 1'b1 || dout !== vals[i] || count !== 3'(2 - i))
        $display("FAIL order_read%0d: valid=%b data=%h count=%0d, need 1 %h %0d", i, valid, dout, count, vals[i], 2 - i);
      else passed++;
    end
    idle();
    cycle();
    total++;
    if (empty !== 1'b1 || valid !== 1'b0 || dout !== 8'h33)
      $display("FAIL order_end: empty=%b valid=%b data=%h, need 1 0 33", empty, valid, dout);
    else passed++;
  endtask

  task automatic test_overflow_full_rdwr();
    logic [DW-1:0] expd [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
    for (int i = 1; i <= 4; i++) begin
      wr = 1'b1; din = 8'(i);
      cycle();
    end
    total++;
    if (full !== 1'b1 || count !== 3'd4) $display("FAIL fill: full=%b count=%0d need 1 4", full, count); else passed++;
    din = 8'hAA;
    cycle();
    total++;
    if (full !== 1'b1 || ovf !== 1'b1 || count !== 3'd4)
      $display("FAIL overflow: full=%b ovf=%b count=%0d need 1 1 4", full, ovf, count);
    else passed++;
    wr = 1'b0; clr = 1'b1;
    cycle();
    total++;
    if (ovf !== 1'b0) $display("FAIL overflow_clear: got %b need 0", ovf); else passed++;
    clr = 1'b0; wr = 1'b1; rd = 1'b1; din = 8'h55;
    cycle();
    total++;
    if (dout !== 8'h01 || valid !== 1'b1 || count !== 3'd4 || full !== 1'b1)
      $display("FAIL full_rdwr: data=%h valid=%b count=%0d full=%b need 01 1 4 1", dout, valid, count, full);
    else passed++;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (dout !== expd[i] || valid !== 1'b1)
        $display("FAIL full_drain%0d: data=%h valid=%b need %h 1", i, dout, valid, expd[i]);
      else passed++;
    end
    idle();
    total++;
    if (count !== 3'd0 || empty !== 1'b1) $display("FAIL full_drain_end: count=%0d empty=%b need 0 1", count, empty); else passed++;
  endtask

  task automatic test_underflow_wrap();
    rd = 1'b1;
    cycle();
    total++;
    if (udf !== 1'b1 || valid !== 1'b0 || count !== 3'd0)
      $display("FAIL underflow: udf=%b valid=%b count=%0d need 1 0 0", udf, valid, count);
    else passed++;
    wr = 1'b1; din = 8'h3C; clr = 1'b1;
    cycle();
    total++;
    if (udf !== 1'b1 || count !== 3'd1)
      $display("FAIL rdwr_empty_setwins: udf=%b count=%0d need 1 1", udf, count);
    else passed++;
    idle(); clr = 1'b1;
    cycle();
    total++;
    if (udf !== 1'b0) $display("FAIL underflow_clear: got %b need 0", udf); else passed++;
    idle(); rd = 1'b1;
    cycle();
    total++;
    if (dout !== 8'h3C) $display("FAIL rdwr_empty_data: got %h need 3c", dout); else passed++;
    for (int i = 0; i < 10; i++) begin
      idle(); wr = 1'b1; din = 8'(8'h40 + i);
      cycle();
      idle(); rd = 1'b1;
      cycle();
      total++;
      if (dout !== 8'(8'h40 + i) || valid !== 1'b1 || count !== 3'd0)
        $display("FAIL wrap%0d: data=%h valid=%b count=%0d need %h 1 0", i, dout, valid, count, 8'(8'h40 + i));
      else passed++;
    end
    idle();
  endtask
`else
  task automatic test_fwft();
    wr = 1'b1; din = 8'h7E;
    cycle();
    idle();
    total++;
    if (valid !== 1'b0 || count !== 3'd1) $display("FAIL fwft_write_edge: valid=%b count=%0d need 0 1", valid, count); else passed++;
    cycle();
    total++;
    if (valid !== 1'b1 || dout !== 8'h7E || empty !== 1'b0)
      $display("FAIL fwft_head: valid=%b data=%h empty=%b need 1 7e 0", valid, dout, empty);
    else passed++;
    rd = 1'b1;
    cycle();
    idle();
    total++;
    if (valid !== 1'b0 || count !== 3'd0) $display("FAIL fwft_pop: valid=%b count=%0d need 0 0", valid, count); else passed++;
  endtask
`endif

  task automatic test_thresholds();
    logic [4:0] ae_exp = 5'b00011;
    logic [4:0] af_exp = 5'b11000;
    afull_th = 3'd3; aempty_th = 3'd1;
    for (int c = 0; c <= 4; c++) begin
      idle();
      #1;
      total++;
      if (aempty !== ae_exp[c] || afull !== af_exp[c] || count !== 3'(c))
        $display("FAIL thresh_c%0d: aempty=%b afull=%b count=%0d need %b %b %0d", c, aempty, afull, count, ae_exp[c], af_exp[c], c);
      else passed++;
      if (c < 4) begin
        wr = 1'b1; din = 8'(8'hA0 + c);
        cycle();
      end
    end
    idle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      cycle();
    end
    idle();
    cycle();
    total++;
    if (count !== 3'd0) $display("FAIL thresh_drain: count=%0d need 0", count); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 8'(8'hC0 + i);
      cycle();
    end
    idle();
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || valid !== 1'b0)
      $display("FAIL reset_mid: count=%0d empty=%b valid=%b need 0 1 0", count, empty, valid);
    else passed++;
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
`ifndef FIFO_SYNC_PROG_FWFT_EN
    test_order();
    test_overflow_full_rdwr();
    test_underflow_wrap();
`else
    test_fwft();
`endif
    test_thresholds();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
